dds_ctrl: RTL and testbench

Sequencer and port arbiter for the 256x8 DDS waveform RAM (sp_ram_256x8). It owns both RAM ports and loads a waveform table from a byte stream through the write port. It then plays the table back through the read port with a phase accumulator, a frequency tuning word and a phase offset, and delivers registered samples with a valid flag. It sits between the host/config logic and the RAM instance; the RAM itself stays outside this block.

---
 rtl/dds_pkg.sv | 8 +
 rtl/dds_phase_acc.sv | 34 +++
 rtl/dds_ctrl.sv | 85 ++++++++
 tb/tb_dds_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// dds_pkg: shared state encoding and default sizing for the DDS sequencer
package dds_pkg;
  localparam int ACC_W_DEF   = 32;
  localparam int ADDR_W_DEF  = 8;
  localparam int DATA_W_DEF  = 8;
  localparam int TABLE_DEPTH = 2 ** ADDR_W_DEF;
  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;
endpackage

// File: rtl/dds_phase_acc.sv
// dds_phase_acc: phase accumulator with tuning word, phase offset and read address
module dds_phase_acc
  import dds_pkg::*;
#(
  parameter int ACC_W  = ACC_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              s_clk,
  input  logic              s_rst_n,
  input  logic              adv,
  input  logic              sync_clr,
  input  logic [ACC_W-1:0]  ftw_in,
  input  logic              ftw_wr,
  input  logic [ADDR_W-1:0] pho_in,
  input  logic              pho_wr,
  output logic [ADDR_W-1:0] rd_addr
);
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  ftw;
  logic [ADDR_W-1:0] pho;
  // sync_clr outranks accumulation; the address always uses the pre-update phase
  always_ff @(posedge s_clk or negedge s_rst_n)
    if (!s_rst_n) begin
      acc     <= '0;
      ftw     <= '0;
      pho     <= '0;
      rd_addr <= '0;
    end else begin
      if (ftw_wr) ftw <= ftw_in;
      if (pho_wr) pho <= pho_in;
      acc <= sync_clr ? '0 : adv ? acc + ftw : acc;
      if (adv) rd_addr <= acc[ACC_W-1 -: ADDR_W] + pho;
    end
endmodule

// File: rtl/dds_ctrl.sv
// dds_ctrl: loads the DDS waveform RAM from a byte stream and plays it back
module dds_ctrl
  import dds_pkg::*;
#(
  parameter int ACC_W  = ACC_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              s_clk,
  input  logic              s_rst_n,
  input  logic [ACC_W-1:0]  ftw_in,
  input  logic              ftw_wr,
  input  logic [ADDR_W-1:0] pho_in,
  input  logic              pho_wr,
  input  logic              sync_clr,
  input  logic              play_en,
  input  logic              load_start,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              load_done,
  output logic              busy_load,
  output logic [ADDR_W-1:0] ram_rdaddress,
  output logic [ADDR_W-1:0] ram_wraddress,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic [DATA_W-1:0] sin_data,
  output logic              sin_valid
);
  state_t            state;
  logic [ADDR_W-1:0] wr_cnt;
  logic              last_byte;
  logic              play_d1;
  logic              play_d2;
  always_comb begin
    busy_load     = state == LOAD;
    wr_ready      = busy_load;
    ram_wren      = busy_load & wr_valid;
    ram_wraddress = wr_cnt;
    ram_data      = wr_data;
    last_byte     = ram_wren && (wr_cnt == '1);
  end
  dds_phase_acc #(.ACC_W(ACC_W), .ADDR_W(ADDR_W)) u_acc (
    .s_clk    (s_clk),
    .s_rst_n  (s_rst_n),
    .adv      (state == PLAY),
    .sync_clr (sync_clr),
    .ftw_in   (ftw_in),
    .ftw_wr   (ftw_wr),
    .pho_in   (pho_in),
    .pho_wr   (pho_wr),
    .rd_addr  (ram_rdaddress)
  );
  // play_d1/play_d2 track the address->q->sample latency so sin_valid lines up with sin_data
  always_ff @(posedge s_clk or negedge s_rst_n)
    if (!s_rst_n) begin
      state     <= IDLE;
      wr_cnt    <= '0;
      load_done <= 1'b0;
      play_d1   <= 1'b0;
      play_d2   <= 1'b0;
      sin_valid <= 1'b0;
      sin_data  <= '0;
    end else begin
      load_done <= last_byte;
      play_d1   <= state == PLAY;
      play_d2   <= play_d1;
      sin_valid <= play_d2;
      if (play_d2) sin_data <= ram_q;
      if (ram_wren) wr_cnt <= wr_cnt + 1'b1;
      case (state)
        IDLE: if (load_start) begin
                state  <= LOAD;
                wr_cnt <= '0;
              end else if (play_en) state <= PLAY;
        LOAD: if (last_byte) state <= play_en ? PLAY : IDLE;
        PLAY: if (load_start) begin
                state  <= LOAD;
                wr_cnt <= '0;
              end else if (!play_en) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_dds_ctrl.sv
// tb_dds_ctrl: directed scoreboard bench for dds_ctrl with a behavioural RAM
module tb_dds_ctrl;
  import dds_pkg::*;
  localparam int ACC_W = 32, ADDR_W = 8, DATA_W = 8;
  logic s_clk = 0, s_rst_n = 1;
  logic [ACC_W-1:0] ftw_in = '0;
  logic ftw_wr = 0, pho_wr = 0, sync_clr = 0, play_en = 0, load_start = 0, wr_valid = 0;
  logic [ADDR_W-1:0] pho_in = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic wr_ready, load_done, busy_load, ram_wren, sin_valid;
  logic [ADDR_W-1:0] ram_rdaddress, ram_wraddress;
  logic [DATA_W-1:0] ram_data, ram_q, sin_data;
  logic [DATA_W-1:0] mem [TABLE_DEPTH];
  logic [DATA_W-1:0] exp_q [$];
  int n_tests = 0, n_fail = 0;

  dds_ctrl #(.ACC_W(ACC_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .s_clk(s_clk), .s_rst_n(s_rst_n), .ftw_in(ftw_in), .ftw_wr(ftw_wr),
    .pho_in(pho_in), .pho_wr(pho_wr), .sync_clr(sync_clr), .play_en(play_en),
    .load_start(load_start), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .load_done(load_done), .busy_load(busy_load),
    .ram_rdaddress(ram_rdaddress), .ram_wraddress(ram_wraddress),
    .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q),
    .sin_data(sin_data), .sin_valid(sin_valid)
  );

  always #5 s_clk = ~s_clk;

  always @(posedge s_clk) begin
    if (ram_wren) mem[ram_wraddress] <= ram_data;
    ram_q <= mem[ram_rdaddress];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: every presented sample is compared against the oldest expected value
  always @(negedge s_clk)
    if (s_rst_n && sin_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sample_unexpected: got %0h expected none", sin_data);
      end else check("sample", sin_data, exp_q.pop_front());
    end

  task automatic tick;
    @(posedge s_clk);
    #1;
  endtask

  task automatic play(input int n, input bit rise);
    play_en = 1;
    tick;
    for (int k = 0; k < n; k++) begin
      play_en = (k < n - 1);
      if (rise && k < 4) begin
        @(negedge s_clk);
        check("valid_rise", sin_valid, k == 3);
      end
      tick;
    end
    play_en = 0;
  endtask

  task automatic drain;
    repeat (4) tick;
    @(negedge s_clk);
    check("sb_empty", exp_q.size(), 0);
    tick;
  endtask

  task automatic load_seq(input bit gappy, input bit rev, input logic [ADDR_W-1:0] exp_rd);
    for (int i = 0; i < TABLE_DEPTH; i++) begin
      logic [DATA_W-1:0] d;
      d = rev ? 8'(255 - i) : 8'(i);
      wr_valid = 1;
      wr_data = d;
      load_start = (i == 100);
      @(negedge s_clk);
      check("load_wr", {wr_ready, ram_wren, ram_wraddress, ram_data}, {1'b1, 1'b1, 8'(i), d});
      if (i == 50) check("rd_hold", ram_rdaddress, exp_rd);
      tick;
      load_start = 0;
      if (gappy && i < TABLE_DEPTH - 1) begin
        wr_valid = 0;
        @(negedge s_clk);
        check("load_gap", {wr_ready, ram_wren}, 2'b10);
        tick;
      end
    end
    wr_valid = 0;
  endtask

  task automatic check_reset_outs(input string name);
    check({name, "_ctl"}, {wr_ready, ram_wren, busy_load, load_done, sin_valid}, 0);
    check({name, "_rd"}, ram_rdaddress, 0);
    check({name, "_sin"}, sin_data, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    #2 s_rst_n = 0;
    #1 check_reset_outs("reset");
    @(negedge s_clk);
    @(negedge s_clk) s_rst_n = 1;
    tick;
    // ramp load, no gaps
    load_start = 1;
    tick;
    load_start = 0;
    load_seq(0, 0, 0);
    @(negedge s_clk);
    check("load_done_pulse", {load_done, wr_ready, busy_load}, 3'b100);
    tick;
    @(negedge s_clk);
    check("load_done_once", load_done, 0);
    tick;
    // unit step playback with wrap
    ftw_in = 32'h0100_0000; ftw_wr = 1; pho_in = 0; pho_wr = 1;
    tick;
    ftw_wr = 0; pho_wr = 0;
    for (int k = 0; k < 260; k++) exp_q.push_back(8'(k));
    play(260, 1);
    drain;
    // half step with offset, offset changed mid-stream
    sync_clr = 1; ftw_in = 32'h0080_0000; ftw_wr = 1; pho_in = 8'h10; pho_wr = 1;
    tick;
    sync_clr = 0; ftw_wr = 0; pho_wr = 0;
    for (int k = 0; k < 18; k++) exp_q.push_back(k < 9 ? 8'(8'h10 + k / 2) : 8'(8'hF8 + k / 2));
    play_en = 1;
    tick;
    for (int k = 0; k < 18; k++) begin
      pho_in = 8'hF8;
      pho_wr = (k == 8);
      play_en = (k < 17);
      tick;
    end
    pho_wr = 0; play_en = 0;
    drain;
    // pause and resume keeps phase, sync_clr restarts
    sync_clr = 1; ftw_in = 32'h0100_0000; ftw_wr = 1; pho_in = 0; pho_wr = 1;
    tick;
    sync_clr = 0; ftw_wr = 0; pho_wr = 0;
    for (int k = 0; k <= 8'h40; k++) exp_q.push_back(8'(k));
    play(8'h41, 0);
    repeat (3) tick;
    @(negedge s_clk);
    check("pause_valid", sin_valid, 0);
    check("pause_hold", sin_data, 8'h40);
    tick;
    for (int k = 8'h41; k <= 8'h44; k++) exp_q.push_back(8'(k));
    play(4, 0);
    drain;
    sync_clr = 1;
    tick;
    sync_clr = 0;
    for (int k = 0; k < 3; k++) exp_q.push_back(8'(k));
    play(3, 0);
    drain;
    // load preempts play, gappy stream, second load_start ignored, play resumes
    for (int k = 3; k <= 13; k++) exp_q.push_back(8'(k));
    for (int k = 0; k < 6; k++) exp_q.push_back(8'(255 - (14 + k)));
    play_en = 1;
    tick;
    for (int k = 0; k <= 10; k++) begin
      load_start = (k == 10);
      tick;
    end
    load_start = 0;
    load_seq(1, 1, 8'd13);
    for (int k = 0; k < 6; k++) begin
      if (k == 0) begin
        @(negedge s_clk);
        check("preempt_done", {load_done, busy_load}, 2'b10);
      end
      play_en = (k < 5);
      tick;
    end
    play_en = 0;
    drain;
    // async reset mid-load, then a clean reload
    load_start = 1;
    tick;
    load_start = 0;
    for (int i = 0; i < 100; i++) begin
      wr_valid = 1;
      wr_data = 8'(i);
      tick;
    end
    #2 s_rst_n = 0;
    #1 check_reset_outs("midload_rst");
    @(negedge s_clk) s_rst_n = 1;
    wr_valid = 0;
    tick;
    load_start = 1;
    tick;
    load_start = 0;
    load_seq(0, 0, 0);
    @(negedge s_clk);
    check("reload_done", load_done, 1);
    tick;
    for (int k = 0; k < 3; k++) exp_q.push_back(8'h00);
    play(3, 0);
    drain;
    ftw_in = 32'h0100_0000; ftw_wr = 1; pho_in = 8'h05; pho_wr = 1;
    tick;
    ftw_wr = 0; pho_wr = 0;
    for (int k = 5; k < 8; k++) exp_q.push_back(8'(k));
    play(3, 0);
    drain;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
